// File: rtl/y86_pipe_control_if.sv
// ============================================================================
// Module   : y86_pipe_control_if
// Purpose  : Stage-register hazard inputs and stall/bubble/debug outputs of
//            the Y86-64 pipeline control unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface y86_pipe_control_if #(
    parameter int CNT_W = 32
);
    logic [3:0]       D_icode;
    logic [3:0]       d_srcA;
    logic [3:0]       d_srcB;
    logic [3:0]       E_icode;
    logic [3:0]       E_dstM;
    logic             e_Cnd;
    logic [3:0]       M_icode;
    logic [1:0]       m_stat;
    logic [3:0]       W_icode;
    logic [1:0]       W_stat;

    logic             F_stall;
    logic             D_stall;
    logic             D_bubble;
    logic             E_bubble;
    logic             M_bubble;
    logic             W_stall;
    logic             halted;
    logic [1:0]       halt_stat;
    logic             flushing;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] ret_cnt;
    logic [CNT_W-1:0] lu_cnt;
    logic [CNT_W-1:0] mp_cnt;

    modport master (
        output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd,
               M_icode, m_stat, W_icode, W_stat,
        input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
               halted, halt_stat, flushing, cyc_cnt, ret_cnt, lu_cnt, mp_cnt
    );

    modport slave (
        input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd,
               M_icode, m_stat, W_icode, W_stat,
        output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
               halted, halt_stat, flushing, cyc_cnt, ret_cnt, lu_cnt, mp_cnt
    );
endinterface

`default_nettype wire

// File: rtl/y86_pipe_control.sv
// ============================================================================
// Module   : y86_pipe_control
// Purpose  : Y86-64 five-stage pipeline hazard control with post-reset flush,
//            halt-on-exception state and saturating debug counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module y86_pipe_control #(
    parameter int FLUSH_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input  wire logic         clk,
    input  wire logic         rst,
    y86_pipe_control_if.slave bus
);
    localparam logic [1:0] c_ST_FLUSH  = 2'd0;
    localparam logic [1:0] c_ST_RUN    = 2'd1;
    localparam logic [1:0] c_ST_HALTED = 2'd2;

    localparam logic [3:0] c_ICODE_NOP    = 4'h1;
    localparam logic [3:0] c_ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] c_ICODE_JXX    = 4'h7;
    localparam logic [3:0] c_ICODE_RET    = 4'h9;
    localparam logic [3:0] c_ICODE_POPQ   = 4'hB;
    localparam logic [3:0] c_REG_NONE     = 4'hF;
    localparam logic [1:0] c_STAT_AOK     = 2'd0;
    localparam logic [3:0] c_FLUSH_LAST   = 4'(FLUSH_CYCLES - 1);

    logic [1:0]       r_state;
    logic [3:0]       r_flush_cnt;
    logic [1:0]       r_halt_stat;
    logic [CNT_W-1:0] r_cyc_cnt;
    logic [CNT_W-1:0] r_ret_cnt;
    logic [CNT_W-1:0] r_lu_cnt;
    logic [CNT_W-1:0] r_mp_cnt;

    logic w_lu;
    logic w_mp;
    logic w_rt;
    logic w_exc;
    logic w_w_bad;
    logic w_retire;

    logic w_f_stall;
    logic w_d_stall;
    logic w_d_bubble;
    logic w_e_bubble;
    logic w_m_bubble;
    logic w_w_stall;

    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign w_lu = ((bus.E_icode == c_ICODE_MRMOVQ) || (bus.E_icode == c_ICODE_POPQ)) &&
                  (bus.E_dstM != c_REG_NONE) &&
                  ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
    assign w_mp     = (bus.E_icode == c_ICODE_JXX) && !bus.e_Cnd;
    assign w_rt     = (bus.D_icode == c_ICODE_RET) || (bus.E_icode == c_ICODE_RET) ||
                      (bus.M_icode == c_ICODE_RET);
    assign w_w_bad  = (bus.W_stat != c_STAT_AOK);
    assign w_exc    = (bus.m_stat != c_STAT_AOK) || w_w_bad;
    assign w_retire = (bus.W_icode != c_ICODE_NOP) && !w_w_bad;

    always_comb begin
        w_f_stall  = 1'b0;
        w_d_stall  = 1'b0;
        w_d_bubble = 1'b0;
        w_e_bubble = 1'b0;
        w_m_bubble = 1'b0;
        w_w_stall  = 1'b0;
        case (r_state)
            c_ST_FLUSH: begin
                w_f_stall  = 1'b1;
                w_d_bubble = 1'b1;
                w_e_bubble = 1'b1;
                w_m_bubble = 1'b1;
            end
            c_ST_RUN: begin
                // Load-use wins over ret in D: stalling keeps the ret visible.
                w_f_stall  = w_lu | w_rt;
                w_d_stall  = w_lu;
                w_d_bubble = w_mp | (w_rt & !w_lu);
                w_e_bubble = w_mp | w_lu;
                w_m_bubble = w_exc;
                w_w_stall  = w_w_bad;
            end
            c_ST_HALTED: begin
                w_f_stall  = 1'b1;
                w_d_stall  = 1'b1;
                w_e_bubble = 1'b1;
                w_m_bubble = 1'b1;
                w_w_stall  = 1'b1;
            end
            default: begin
                w_f_stall  = 1'b1;
                w_d_bubble = 1'b1;
                w_e_bubble = 1'b1;
                w_m_bubble = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_FLUSH;
            r_flush_cnt <= 4'd0;
            r_halt_stat <= c_STAT_AOK;
            r_cyc_cnt   <= '0;
            r_ret_cnt   <= '0;
            r_lu_cnt    <= '0;
            r_mp_cnt    <= '0;
        end else begin
            case (r_state)
                c_ST_FLUSH: begin
                    if (r_flush_cnt == c_FLUSH_LAST) begin
                        r_state <= c_ST_RUN;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + 4'd1;
                    end
                end
                c_ST_RUN: begin
                    // Counters still account for the cycle that enters HALTED.
                    r_cyc_cnt <= f_sat_inc(r_cyc_cnt);
                    if (w_retire) r_ret_cnt <= f_sat_inc(r_ret_cnt);
                    if (w_lu)     r_lu_cnt  <= f_sat_inc(r_lu_cnt);
                    if (w_mp)     r_mp_cnt  <= f_sat_inc(r_mp_cnt);
                    if (w_w_bad) begin
                        r_state     <= c_ST_HALTED;
                        r_halt_stat <= bus.W_stat;
                    end
                end
                c_ST_HALTED: begin
                    r_state <= c_ST_HALTED;
                end
                default: begin
                    r_state     <= c_ST_FLUSH;
                    r_flush_cnt <= 4'd0;
                end
            endcase
        end
    end

    assign bus.F_stall   = w_f_stall;
    assign bus.D_stall   = w_d_stall;
    assign bus.D_bubble  = w_d_bubble;
    assign bus.E_bubble  = w_e_bubble;
    assign bus.M_bubble  = w_m_bubble;
    assign bus.W_stall   = w_w_stall;
    assign bus.halted    = (r_state == c_ST_HALTED);
    assign bus.flushing  = (r_state == c_ST_FLUSH);
    assign bus.halt_stat = r_halt_stat;
    assign bus.cyc_cnt   = r_cyc_cnt;
    assign bus.ret_cnt   = r_ret_cnt;
    assign bus.lu_cnt    = r_lu_cnt;
    assign bus.mp_cnt    = r_mp_cnt;
endmodule

`default_nettype wire

// File: doc/y86_pipe_control.md
Name: y86_pipe_control

Overview:
- Pipeline control unit for the five-stage Y86-64 pipeline.
- Decodes hazard conditions from the D/E/M/W stage registers and drives the stall and bubble controls. This includes F_stall, D_stall and D_bubble into the fetch stage.
- Runs a post-reset flush sequence and a terminal halt state on non-AOK writeback status.
- Keeps saturating event counters for debug.

Parameters:
- FLUSH_CYCLES, 4: cycles of forced flush after reset release; legal range 1..15.
- CNT_W, 32: width of each event counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- D_icode  in  4  icode in the decode register.
- d_srcA  in  4  decode-stage source A register ID; 4'hF means none.
- d_srcB  in  4  decode-stage source B register ID; 4'hF means none.
- E_icode  in  4  icode in the execute register.
- E_dstM  in  4  execute-stage memory destination register ID; 4'hF means none.
- e_Cnd  in  1  execute-stage condition result.
- M_icode  in  4  icode in the memory register.
- m_stat  in  2  memory-stage status after data access.
- W_icode  in  4  icode in the writeback register.
- W_stat  in  2  writeback status.
- F_stall  out  1  hold PC.
- D_stall  out  1  hold D register.
- D_bubble  out  1  load NOP into D.
- E_bubble  out  1  load NOP into E.
- M_bubble  out  1  load NOP into M.
- W_stall  out  1  hold W register.
- halted  out  1  state == HALTED.
- halt_stat  out  2  W_stat latched on entry to HALTED.
- flushing  out  1  state == FLUSH.
- cyc_cnt  out  CNT_W  cycles spent in RUN.
- ret_cnt  out  CNT_W  retired instructions.
- lu_cnt  out  CNT_W  load-use stall cycles.
- mp_cnt  out  CNT_W  mispredicted jumps.

Behaviour:
- Encodings:
  - Stat: 0 AOK, 1 HLT, 2 ADR, 3 INS.
  - icode: NOP 1, JXX 7, RET 9, MRMOVQ 5, POPQ B.
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=FLUSH, flush counter=0, halt_stat=0, all counters 0, halted=0, flushing=1.
- States:
  - FLUSH: F_stall=1, D_bubble=1, E_bubble=1, M_bubble=1, D_stall=0, W_stall=0. Stays FLUSH for FLUSH_CYCLES clock edges after rst deasserts, then goes to RUN. Hazard inputs are ignored.
  - RUN: outputs come from the combinational hazard equations below, so they have zero latency from the inputs. Goes to HALTED on any edge where W_stat != 0, latching halt_stat <= W_stat.
  - HALTED: F_stall=1, D_stall=1, E_bubble=1, M_bubble=1, W_stall=1, D_bubble=0. Exited only by rst. Counters freeze.
- Hazard terms, evaluated in RUN only:
  - lu = (E_icode==5 or E_icode==B) and E_dstM != F and (E_dstM==d_srcA or E_dstM==d_srcB).
  - mp = E_icode==7 and !e_Cnd.
  - rt = 9 appears in D_icode, E_icode or M_icode.
  - exc = m_stat != 0 or W_stat != 0.
- Hazard outputs in RUN:
  - F_stall = lu | rt.
  - D_stall = lu.
  - D_bubble = mp | (rt & !lu).
  - E_bubble = mp | lu.
  - M_bubble = exc.
  - W_stall = W_stat != 0.
- Combined hazards: lu and rt together give D_stall=1, D_bubble=0. D_stall and D_bubble are never both 1 in any state.
- Counters, updated in RUN only; each saturates at all-ones and never wraps:
  - cyc_cnt increments every RUN cycle.
  - ret_cnt increments when W_icode != 1 and W_stat == 0.
  - lu_cnt increments when lu.
  - mp_cnt increments when mp.
- Ordering: in the cycle that enters HALTED, counter updates for that cycle still apply.
- rst during any state returns to FLUSH and clears the flush counter, halt_stat and all counters.

Test Plan:
- Reset and flush: rst high 2 cycles, then low -> flushing=1 and F_stall/D_bubble/E_bubble/M_bubble=1 for exactly 4 cycles, then RUN with all controls 0 given idle inputs (icodes=1, stats=0).
- Load-use: E_icode=5, E_dstM=3, d_srcB=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; lu_cnt +1 per cycle held. Same case with E_dstM=F and d_srcA=F -> no stall.
- Mispredict and ret: E_icode=7, e_Cnd=0 -> D_bubble=1, E_bubble=1, mp_cnt +1. Then M_icode=9 alone -> F_stall=1, D_bubble=1.
- Combined ret and load-use: E_icode=B, E_dstM=4, d_srcA=4, D_icode=9 -> D_stall=1, D_bubble=0, F_stall=1.
- Halt: m_stat=2 -> M_bubble=1. Next cycle W_stat=2 -> W_stall=1, and at the edge halted=1, halt_stat=2. Counters stay frozen over 10 further cycles; rst returns to FLUSH.
- Saturation: with CNT_W=4, 20 RUN cycles -> cyc_cnt stays at 15.
